// File: rtl/mux_pkg.sv
// Shared constants for the 4-to-1 mux scan controller and the mux4to1 variants.
package mux_pkg;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   typedef logic [SEL_W-1:0]  sel_t;
   typedef logic [NUM_CH-1:0] snap_t;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam sel_t SEL_LAST = sel_t'(NUM_CH - 1);

endpackage

// File: rtl/hold_timer.sv
// Hold-window counter: counts while enabled, tc marks the last cycle of the window.
module hold_timer #(
   parameter int HOLD = 2,
   parameter int CW   = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam logic [CW-1:0] TC_VAL = CW'(HOLD - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   assign tc = (cnt_q == TC_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = tc ? '0 : cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Steps a 4-to-1 mux select through 0..3, samples the mux output after each hold
// window and publishes the 4-bit snapshot with a one-cycle done pulse.
//
//   state | meaning
//   IDLE  | sel=0, waiting for start
//   SCAN  | holding sel, sampling mux_out on timer terminal count
//   DONE  | one cycle: result updated, done=1, sel held at 3
module mux4_scan_ctrl
   import mux_pkg::*;
#(
   parameter int HOLD = 2,
   parameter int CW   = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   input  logic       mux_out,
   output logic [1:0] sel,
   output logic       busy,
   output logic       done,
   output logic [3:0] result
);

   logic [1:0] state_q, state_d;
   sel_t       sel_q, sel_d;
   snap_t      shadow_q, shadow_d;
   snap_t      result_q, result_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;
   logic       tc;

   // Timer is held clear outside SCAN so every scan starts a fresh window.
   hold_timer #(
      .HOLD (HOLD),
      .CW   (CW)
   ) u_hold_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (state_q != ST_SCAN),
      .en    (state_q == ST_SCAN),
      .tc    (tc)
   );

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      shadow_d = shadow_q;
      result_d = result_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            sel_d  = '0;
            busy_d = 1'b0;
            if (start) begin
               state_d  = ST_SCAN;
               shadow_d = '0;
               busy_d   = 1'b1;
            end
         end
         ST_SCAN: begin
            busy_d = 1'b1;
            if (tc) begin
               shadow_d[sel_q] = mux_out;
               if (sel_q == SEL_LAST) begin
                  state_d  = ST_DONE;
                  done_d   = 1'b1;
                  result_d = shadow_d;
               end else begin
                  sel_d = sel_q + sel_t'(1);
               end
            end
         end
         ST_DONE: begin
            sel_d = '0;
            if (cont) begin
               state_d  = ST_SCAN;
               shadow_d = '0;
               busy_d   = 1'b1;
            end else begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sel_d   = '0;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         sel_q    <= '0;
         shadow_q <= '0;
         result_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         shadow_q <= shadow_d;
         result_q <= result_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign sel    = sel_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: HOLD=2 instance (a) and HOLD=1 instance (b), each
// feeding a behavioural 4-to-1 mux; expected snapshots go through a scoreboard queue.
module tb_mux4_scan_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n = 1'b0;

   logic       start_a = 1'b0, cont_a = 1'b0, mux_a;
   logic [3:0] pat_a = 4'h0, result_a;
   logic [1:0] sel_a;
   logic       busy_a, done_a;
   int         vsel_a = 0;

   logic       start_b = 1'b0, cont_b = 1'b0, mux_b;
   logic [3:0] pat_b = 4'h0, result_b;
   logic [1:0] sel_b;
   logic       busy_b, done_b;
   int         vsel_b = 0;

   int errors = 0;
   int checks = 0;
   logic [3:0] exp_a[$];
   logic [3:0] exp_b[$];

   // Three mux4to1 styles: 0 = 2:1 tree (inst), 1 = if chain, 2 = case.
   function automatic logic mux_fn(input int v, input logic [3:0] d, input logic [1:0] s);
      logic lo, hi, r;
      r = 1'b0;
      if (v == 0) begin
         lo = s[0] ? d[1] : d[0];
         hi = s[0] ? d[3] : d[2];
         r  = s[1] ? hi : lo;
      end else if (v == 1) begin
         if (s == 2'd0)      r = d[0];
         else if (s == 2'd1) r = d[1];
         else if (s == 2'd2) r = d[2];
         else                r = d[3];
      end else begin
         case (s)
            2'd0:    r = d[0];
            2'd1:    r = d[1];
            2'd2:    r = d[2];
            default: r = d[3];
         endcase
      end
      return r;
   endfunction

   assign mux_a = mux_fn(vsel_a, pat_a, sel_a);
   assign mux_b = mux_fn(vsel_b, pat_b, sel_b);

   mux4_scan_ctrl #(.HOLD(2), .CW(4)) dut_a (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_a),
      .cont    (cont_a),
      .mux_out (mux_a),
      .sel     (sel_a),
      .busy    (busy_a),
      .done    (done_a),
      .result  (result_a)
   );

   mux4_scan_ctrl #(.HOLD(1), .CW(4)) dut_b (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start_b),
      .cont    (cont_b),
      .mux_out (mux_b),
      .sel     (sel_b),
      .busy    (busy_b),
      .done    (done_b),
      .result  (result_b)
   );

   // Start accepted at the second posedge; caller resumes just after that edge.
   task automatic pulse_start_a();
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      checks++;
      if ({sel_a, busy_a, done_a, result_a} !== 8'h00)
         $display("FAIL reset_a: sel=%0d busy=%b done=%b result=%b, want all zero",
                  sel_a, busy_a, done_a, result_a);
      checks++;
      if ({sel_b, busy_b, done_b, result_b} !== 8'h00)
         $display("FAIL reset_b: sel=%0d busy=%b done=%b result=%b, want all zero",
                  sel_b, busy_b, done_b, result_b);
      if (({sel_a, busy_a, done_a, result_a} !== 8'h00) ||
          ({sel_b, busy_b, done_b, result_b} !== 8'h00)) errors++;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_basic();
      logic [3:0] e;
      logic [1:0] es;
      pat_a  = 4'b1010;
      vsel_a = 0;
      exp_a.push_back(pat_a);
      pulse_start_a();
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         es = 2'(c / 2);
         checks++;
         if (sel_a !== es || busy_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("FAIL basic_seq c=%0d: sel=%0d busy=%b done=%b, want sel=%0d busy=1 done=0",
                     c, sel_a, busy_a, done_a, es);
         end
      end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b1 || busy_a !== 1'b1 || sel_a !== 2'd3) begin
         errors++;
         $display("FAIL basic_done: done=%b busy=%b sel=%0d, want 1 1 3", done_a, busy_a, sel_a);
      end
      if (done_a === 1'b1) begin
         e = exp_a.pop_front();
         checks++;
         if (result_a !== e) begin
            errors++;
            $display("FAIL basic_result: got %b want %b", result_a, e);
         end
      end
      @(negedge clk);
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 2'd0) begin
         errors++;
         $display("FAIL basic_after: done=%b busy=%b sel=%0d, want 0 0 0", done_a, busy_a, sel_a);
      end
      pat_a = 4'b0101;
      repeat (3) @(negedge clk);
      checks++;
      if (result_a !== 4'b1010 || busy_a !== 1'b0) begin
         errors++;
         $display("FAIL basic_hold: result=%b busy=%b, want 1010 0", result_a, busy_a);
      end
   endtask

   task automatic test_reset_mid();
      bit found = 0;
      bit seen = 0;
      logic [3:0] e;
      pat_a = 4'b0110;
      exp_a.push_back(pat_a);
      pulse_start_a();
      for (int n = 0; n < 10 && !found; n++) begin
         @(negedge clk);
         if (sel_a === 2'd2) found = 1;
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rstmid_reach: sel never reached 2, sel=%0d", sel_a);
      end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({sel_a, busy_a, done_a, result_a} !== 8'h00) begin
         errors++;
         $display("FAIL rstmid_async: sel=%0d busy=%b done=%b result=%b, want all zero",
                  sel_a, busy_a, done_a, result_a);
      end
      exp_a.delete();
      @(negedge clk);
      rst_n = 1'b1;
      pat_a = 4'b0011;
      exp_a.push_back(pat_a);
      pulse_start_a();
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (done_a === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL rstmid_timeout: no done after reset release, result=%b", result_a);
      end else begin
         e = exp_a.pop_front();
         checks++;
         if (result_a !== e) begin
            errors++;
            $display("FAIL rstmid_result: got %b want %b", result_a, e);
         end
      end
   endtask

   task automatic test_busy_ignore();
      int dones = 0;
      int done_at = -1;
      bit seen = 0;
      logic [3:0] e;
      pat_a = 4'b1100;
      exp_a.push_back(pat_a);
      pulse_start_a();
      for (int c = 0; c < 14; c++) begin
         @(negedge clk);
         if (done_a === 1'b1) begin
            dones++;
            done_at = c;
            checks++;
            if (exp_a.size() == 0) begin
               errors++;
               $display("FAIL busy_extra_done: at c=%0d result=%b, want no done", c, result_a);
            end else begin
               e = exp_a.pop_front();
               if (result_a !== e) begin
                  errors++;
                  $display("FAIL busy_result: got %b want %b", result_a, e);
               end
            end
         end
         if (c >= 10) begin
            checks++;
            if (busy_a !== 1'b0) begin
               errors++;
               $display("FAIL busy_idle c=%0d: busy=%b want 0", c, busy_a);
            end
         end
         if (c == 2 || c == 8) start_a = 1'b1;
         if (c == 3 || c == 9) start_a = 1'b0;
      end
      checks++;
      if (dones != 1 || done_at != 8) begin
         errors++;
         $display("FAIL busy_ignore: %0d done pulses, last at c=%0d, want 1 at c=8", dones, done_at);
      end
      pat_a = 4'b0011;
      exp_a.push_back(pat_a);
      pulse_start_a();
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge clk);
         if (done_a === 1'b1) seen = 1;
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL busy_second_timeout: no done, result=%b", result_a);
      end else begin
         e = exp_a.pop_front();
         checks++;
         if (result_a !== e) begin
            errors++;
            $display("FAIL busy_second_result: got %b want %b", result_a, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int d0 = -1;
      int d1 = -1;
      int dones = 0;
      logic [3:0] e;
      pat_a = 4'b1001;
      exp_a.push_back(pat_a);
      exp_a.push_back(pat_a);
      @(posedge clk); #1 start_a = 1'b1;
      @(posedge clk);
      for (int c = 0; c < 26; c++) begin
         @(negedge clk);
         if (c == 9) begin
            checks++;
            if (busy_a !== 1'b0) begin
               errors++;
               $display("FAIL b2b_idle_gap: busy=%b at c=9, want 0", busy_a);
            end
         end
         if (done_a === 1'b1) begin
            dones++;
            if (dones == 1) d0 = c; else d1 = c;
            checks++;
            if (exp_a.size() == 0) begin
               errors++;
               $display("FAIL b2b_extra_done: at c=%0d", c);
            end else begin
               e = exp_a.pop_front();
               if (result_a !== e) begin
                  errors++;
                  $display("FAIL b2b_result: got %b want %b", result_a, e);
               end
            end
            if (dones == 2) start_a = 1'b0;
         end
      end
      start_a = 1'b0;
      checks++;
      if (dones != 2 || d0 != 8 || d1 != 18) begin
         errors++;
         $display("FAIL b2b_timing: dones=%0d at c=%0d,%0d, want 2 at c=8,18", dones, d0, d1);
      end
      exp_a.delete();
   endtask

   task automatic test_cont();
      int dones = 0;
      int d0 = -1;
      int d1 = -1;
      logic [3:0] e;
      cont_b = 1'b1;
      pat_b  = 4'b0110;
      vsel_b = 2;
      exp_b.push_back(pat_b);
      @(posedge clk); #1 start_b = 1'b1;
      @(posedge clk); #1 start_b = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         if (c < 4) begin
            checks++;
            if (sel_b !== 2'(c)) begin
               errors++;
               $display("FAIL cont_sel1 c=%0d: sel=%0d want %0d", c, sel_b, c);
            end
         end
         if (c >= 5 && c <= 8) begin
            checks++;
            if (sel_b !== 2'(c - 5) || busy_b !== 1'b1) begin
               errors++;
               $display("FAIL cont_sel2 c=%0d: sel=%0d busy=%b want %0d 1", c, sel_b, busy_b, c - 5);
            end
         end
         if (c >= 10) begin
            checks++;
            if (busy_b !== 1'b0 || sel_b !== 2'd0) begin
               errors++;
               $display("FAIL cont_stop c=%0d: busy=%b sel=%0d want 0 0", c, busy_b, sel_b);
            end
         end
         if (done_b === 1'b1) begin
            dones++;
            checks++;
            if (exp_b.size() == 0) begin
               errors++;
               $display("FAIL cont_extra_done: at c=%0d result=%b", c, result_b);
            end else begin
               e = exp_b.pop_front();
               if (result_b !== e) begin
                  errors++;
                  $display("FAIL cont_result: got %b want %b at c=%0d", result_b, e, c);
               end
            end
            if (dones == 1) begin
               d0 = c;
               pat_b = 4'b1001;
               exp_b.push_back(pat_b);
            end else begin
               d1 = c;
            end
         end
         if (c == 6) cont_b = 1'b0;
      end
      checks++;
      if (dones != 2 || d0 != 4 || d1 != 9) begin
         errors++;
         $display("FAIL cont_timing: dones=%0d at c=%0d,%0d, want 2 at c=4,9", dones, d0, d1);
      end
   endtask

   task automatic test_mux_variants();
      logic [3:0] e;
      bit seen;
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 8; i++) begin
            vsel_a = v;
            pat_a  = 4'($urandom_range(0, 15));
            exp_a.push_back(pat_a);
            pulse_start_a();
            seen = 0;
            for (int n = 0; n < 20 && !seen; n++) begin
               @(negedge clk);
               if (done_a === 1'b1) seen = 1;
            end
            checks++;
            if (!seen) begin
               errors++;
               $display("FAIL variant%0d_timeout: scan %0d no done", v, i);
               exp_a.delete();
            end else begin
               e = exp_a.pop_front();
               if (result_a !== e) begin
                  errors++;
                  $display("FAIL variant%0d_result: scan %0d got %b want %b", v, i, result_a, e);
               end
            end
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_reset_mid();
      test_busy_ignore();
      test_back_to_back();
      test_cont();
      test_mux_variants();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
